frame_draw_scheduler: RTL and testbench
=======================================

// Module: frame_draw_scheduler
// PURPOSE
//  Sequences frame_tracker over the game grid once per game tick: issues (x,y) cell queries, captures obj_code/diff,
//  forwards changed cells to the display writer as draw commands over a valid/ready handshake.
//  Sits between the game-tick source (sync) and frame_tracker / LCD draw path; sole owner of the tracker query port.
// PARAMETERS
//  GRID_W  16  cells per row (x range 0..GRID_W-1)
//  GRID_H  16  cells per column (y range 0..GRID_H-1)
//  CW      4   coordinate width; must satisfy 2**CW >= max(GRID_W,GRID_H)
// PORTS
//  clk          in   1        system clock
//  nrst         in   1        reset, synchronous, active-low
//  sync         in   1        frame start pulse (one game tick)
//  force_full   in   1        sampled with accepted sync: redraw every cell this frame
//  trk_en       out  1        tracker query strobe
//  trk_x,trk_y  out  CW       queried cell
//  trk_code     in   obj_code_t  tracker object code, valid cycle after trk_en
//  trk_diff     in   1        cell changed since last frame, valid cycle after trk_en
//  cmd_valid    out  1        draw command valid
//  cmd_ready    in   1        display writer accepts
//  cmd_x,cmd_y  out  CW       cell to draw
//  cmd_code     out  obj_code_t  object to draw
//  busy         out  1        frame scan in progress
//  frame_done   out  1        one-cycle pulse, scan complete
//  overrun      out  1        one-cycle pulse, sync arrived while busy
// BEHAVIOUR
//  Reset (nrst=0 at posedge): state IDLE; every output 0; x=y=0; first_frame=1.
//  FSM: IDLE -> REQ -> CAPT -> (SEND) -> REQ ... -> DONE -> IDLE.
//   IDLE: busy=0. sync=1 -> REQ, x=y=0, full=force_full|first_frame, first_frame<=0.
//   REQ (1 cycle): trk_en=1, trk_x/trk_y = current x/y. -> CAPT.
//   CAPT (1 cycle): register trk_code/trk_diff. If trk_diff|full -> SEND, else advance.
//   SEND: cmd_valid=1; cmd_x/y/code stable until cmd_valid&cmd_ready; on handshake advance.
//   advance: x==GRID_W-1 && y==GRID_H-1 -> DONE; else x==GRID_W-1 -> x=0,y++; else x++; -> REQ.
//   DONE (1 cycle): frame_done=1, busy=1 -> IDLE.
//  busy=1 in REQ/CAPT/SEND/DONE. trk_en only in REQ; cmd_valid only in SEND.
//  Scan order raster: x fastest, y slowest, (0,0) first.
//  Timing, cmd_ready held 1: skipped cell 2 cycles, sent cell 3 cycles; full frame = 3*GRID_W*GRID_H + 1 cycles.
//  Backpressure: cmd_valid never drops and payload never changes before handshake; no deassert-on-timeout.
//  sync while busy (incl. DONE): ignored, overrun=1 that cycle; scan unaffected. sync in IDLE same cycle as
//   frame_done leaving: not possible (DONE->IDLE precedes); sync in IDLE always accepted.
//  force_full sampled only when sync accepted; changes mid-frame ignored.
//  Reset mid-frame: next cycle all outputs 0, state IDLE; next accepted frame is full redraw (first_frame=1).
//  Coordinates never exceed GRID_W-1/GRID_H-1; counters do not wrap past grid.
// STRUCTURE
//  Shared package (snake_pkg): obj_code_t (BLANK,BODY,HEAD,APPLE,BORDER; 3b), sched_state_t enum, GRID_W/GRID_H defaults.
//  Sub-module: cell_scan_counter (x/y raster counter with inc, clear, last flag) instantiated once.
//  Remaining FSM, capture registers and command output registers in this module; all outputs registered.
// TESTING
//  Reset: hold nrst=0 2 cycles -> busy, trk_en, cmd_valid, frame_done, overrun all 0.
//  First frame, cmd_ready=1, trk_diff=0 always -> 256 cmds (0,0),(1,0)..(15,15); frame_done 769 cycles after sync.
//  Second frame, force_full=0, trk_diff=1 only at (3,5) code APPLE -> exactly one cmd (3,5,APPLE); done after 514 cycles.
//  Backpressure: cmd_ready=0 for 10 cycles at (3,5) -> cmd_valid/x/y/code stable all 10; advances the cycle after ready.
//  sync pulse at mid-scan -> overrun=1 one cycle; scan order/count unchanged; single frame_done.
//  nrst=0 during SEND at (7,2) -> outputs 0 next cycle; next sync yields full 256-cmd redraw from (0,0).

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types for the snake display path.
//   obj_code_t    : 3-bit object code reported by frame_tracker and drawn by the LCD writer
//   sched_state_t : frame_draw_scheduler FSM states
//   GRID_*_DEF    : default play-field geometry
package snake_pkg;

  typedef enum logic [2:0] {
    OBJ_BLANK  = 3'd0,
    OBJ_BODY   = 3'd1,
    OBJ_HEAD   = 3'd2,
    OBJ_APPLE  = 3'd3,
    OBJ_BORDER = 3'd4
  } obj_code_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_CAPT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } sched_state_t;

  localparam int GRID_W_DEF = 16;
  localparam int GRID_H_DEF = 16;
  localparam int CW_DEF     = 4;

endpackage

// File: rtl/cell_scan_counter.sv
// Raster cell counter: x runs fastest, y slowest, starting at (0,0).
//   clk, nrst : clock, synchronous active-low reset
//   clear     : return to (0,0)
//   inc       : step to the next cell; holds at the last cell instead of wrapping
//   x, y      : current cell
//   last      : current cell is (GRID_W-1, GRID_H-1)
module cell_scan_counter #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int CW     = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          last
);

  localparam logic [CW-1:0] X_MAX = CW'(GRID_W - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(GRID_H - 1);

  always_ff @(posedge clk) begin
    if (!nrst || clear) begin
      x <= '0;
      y <= '0;
    end else if (inc && !last) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= y + CW'(1);
      end else begin
        x <= x + CW'(1);
      end
    end
  end

  assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/frame_draw_scheduler.sv
// Walks the game grid once per game tick, querying frame_tracker cell by cell and
// forwarding changed cells (or every cell on a full redraw) to the display writer.
//   clk, nrst           : clock, synchronous active-low reset
//   sync, force_full    : frame start pulse; force_full sampled with an accepted sync
//   trk_en/trk_x/trk_y  : tracker query strobe and cell
//   trk_code/trk_diff   : tracker answer, valid the cycle after trk_en
//   cmd_valid/cmd_ready : draw command handshake, payload cmd_x/cmd_y/cmd_code
//   busy                : scan in progress (including the DONE cycle)
//   frame_done          : one-cycle pulse at scan end
//   overrun             : one-cycle pulse, sync seen while busy
module frame_draw_scheduler
  import snake_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          sync,
  input  logic          force_full,
  output logic          trk_en,
  output logic [CW-1:0] trk_x,
  output logic [CW-1:0] trk_y,
  input  obj_code_t     trk_code,
  input  logic          trk_diff,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [CW-1:0] cmd_x,
  output logic [CW-1:0] cmd_y,
  output obj_code_t     cmd_code,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun
);

  sched_state_t  state;
  logic          full;
  logic          first_frame;
  logic          cnt_clear;
  logic          cnt_inc;
  logic          cnt_last;
  logic [CW-1:0] cnt_x;
  logic [CW-1:0] cnt_y;

  cell_scan_counter #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .CW     (CW)
  ) u_scan (
    .clk   (clk),
    .nrst  (nrst),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .x     (cnt_x),
    .y     (cnt_y),
    .last  (cnt_last)
  );

  // The counter holds the cell being queried, so it doubles as the query address.
  assign trk_x = cnt_x;
  assign trk_y = cnt_y;

  always_comb begin
    cnt_clear = (state == ST_IDLE) && sync;
    cnt_inc   = ((state == ST_CAPT) && !(trk_diff || full)) ||
                ((state == ST_SEND) && cmd_ready);
  end

  // Stage: FSM and registered outputs
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= ST_IDLE;
      full        <= 1'b0;
      first_frame <= 1'b1;
      trk_en      <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_x       <= '0;
      cmd_y       <= '0;
      cmd_code    <= OBJ_BLANK;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      trk_en     <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= sync && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (sync) begin
            state       <= ST_REQ;
            busy        <= 1'b1;
            trk_en      <= 1'b1;
            full        <= force_full || first_frame;
            first_frame <= 1'b0;
          end
        end
        ST_REQ: begin
          state <= ST_CAPT;
        end
        ST_CAPT: begin
          if (trk_diff || full) begin
            state     <= ST_SEND;
            cmd_valid <= 1'b1;
            cmd_x     <= cnt_x;
            cmd_y     <= cnt_y;
            cmd_code  <= trk_code;
          end else if (cnt_last) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
          end else begin
            state  <= ST_REQ;
            trk_en <= 1'b1;
          end
        end
        ST_SEND: begin
          // Payload is frozen until the writer takes it; no timeout path.
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            if (cnt_last) begin
              state      <= ST_DONE;
              frame_done <= 1'b1;
            end else begin
              state  <= ST_REQ;
              trk_en <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Self-checking bench for frame_draw_scheduler: a negedge environment process plays the
// tracker and the display writer and logs activity; test tasks compare the logs with
// expectations derived from the grid rules (raster order, diff|full selection, cycle cost).
module tb_frame_draw_scheduler;
  import snake_pkg::*;

  localparam int GW    = 16;
  localparam int GH    = 16;
  localparam int CW    = 4;
  localparam int NCELL = GW * GH;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [2:0]    code;
  } cmd_t;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          sync = 1'b0;
  logic          force_full = 1'b0;
  logic          trk_en;
  logic [CW-1:0] trk_x;
  logic [CW-1:0] trk_y;
  obj_code_t     trk_code = OBJ_BLANK;
  logic          trk_diff = 1'b0;
  logic          cmd_valid;
  logic          cmd_ready = 1'b1;
  logic [CW-1:0] cmd_x;
  logic [CW-1:0] cmd_y;
  obj_code_t     cmd_code;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  frame_draw_scheduler #(.GRID_W(GW), .GRID_H(GH), .CW(CW)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .sync       (sync),
    .force_full (force_full),
    .trk_en     (trk_en),
    .trk_x      (trk_x),
    .trk_y      (trk_y),
    .trk_code   (trk_code),
    .trk_diff   (trk_diff),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_code   (cmd_code),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Tracker contents and environment logs
  logic       diff_map [NCELL];
  logic [2:0] code_map [NCELL];
  int   q_log[$];
  int   q_cyc[$];
  cmd_t cmd_q[$];
  cmd_t bp_q[$];
  cmd_t exp_q[$];
  int   cyc = 0;
  int   busy_cycles, done_count, overrun_count, stall_cycles;
  int   ready_mode = 0;
  int   stall_x, stall_y;
  int   stall_left = 0;
  int   target_hs_cyc = -1;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(negedge clk) begin : env
    int   idx;
    cmd_t c;
    cyc++;
    if (trk_en) begin
      idx = int'(trk_y) * GW + int'(trk_x);
      q_log.push_back(idx);
      q_cyc.push_back(cyc);
      trk_code = obj_code_t'(code_map[idx]);
      trk_diff = diff_map[idx];
    end
    if (busy) busy_cycles++;
    if (frame_done) done_count++;
    if (overrun) overrun_count++;
    c.x = cmd_x;
    c.y = cmd_y;
    c.code = cmd_code;
    case (ready_mode)
      0: cmd_ready = 1'b1;
      1: cmd_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (cmd_valid && int'(cmd_x) == stall_x && int'(cmd_y) == stall_y && stall_left > 0) begin
          cmd_ready = 1'b0;
          stall_left--;
          bp_q.push_back(c);
        end else begin
          cmd_ready = 1'b1;
        end
      end
    endcase
    if (cmd_valid && !cmd_ready) stall_cycles++;
    if (cmd_valid && cmd_ready) begin
      cmd_q.push_back(c);
      if (int'(cmd_x) == stall_x && int'(cmd_y) == stall_y) target_hs_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    q_log.delete();
    q_cyc.delete();
    cmd_q.delete();
    bp_q.delete();
    busy_cycles   = 0;
    done_count    = 0;
    overrun_count = 0;
    stall_cycles  = 0;
    target_hs_cyc = -1;
  endtask

  task automatic set_maps(input int density_pct);
    for (int i = 0; i < NCELL; i++) begin
      diff_map[i] = ($urandom_range(0, 99) < density_pct);
      code_map[i] = 3'($urandom_range(0, 4));
    end
  endtask

  // Reference: cells drawn in raster order are exactly those changed, or all on a full frame.
  task automatic build_model(input bit full);
    cmd_t e;
    exp_q.delete();
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++)
        if (full || diff_map[y * GW + x]) begin
          e.x = CW'(x);
          e.y = CW'(y);
          e.code = code_map[y * GW + x];
          exp_q.push_back(e);
        end
  endtask

  function automatic int cmd_mismatches();
    int bad = 0;
    if (cmd_q.size() != exp_q.size()) bad++;
    for (int i = 0; i < cmd_q.size() && i < exp_q.size(); i++)
      if (cmd_q[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  function automatic int query_mismatches();
    int bad = 0;
    if (q_log.size() != NCELL) bad++;
    for (int i = 0; i < q_log.size() && i < NCELL; i++)
      if (q_log[i] != i) bad++;
    return bad;
  endfunction

  // Called at posedge+1; sync is seen by the DUT at the following edge.
  task automatic start_frame(input logic ff);
    sync = 1'b1;
    force_full = ff;
    @(posedge clk); #1;
    sync = 1'b0;
    force_full = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int start = done_count;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_count > start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (trk_en !== 1'b0) begin n_fail++; $display("FAIL reset_trk_en got=%b exp=0", trk_en); end
    n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid got=%b exp=0", cmd_valid); end
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    n_tests++;
    if ({trk_x, trk_y, cmd_x, cmd_y} !== '0) begin
      n_fail++;
      $display("FAIL reset_coords got=%h exp=0", {trk_x, trk_y, cmd_x, cmd_y});
    end
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_first_frame();
    bit ok;
    set_maps(0);
    ready_mode = 0;
    clear_logs();
    build_model(1'b1);
    start_frame(1'b0);
    wait_done(2000, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL first_timeout got=no frame_done exp=frame_done"); end
    n_tests++; if (cmd_q.size() != NCELL) begin n_fail++; $display("FAIL first_cmd_count got=%0d exp=%0d", cmd_q.size(), NCELL); end
    n_tests++; if (cmd_mismatches() != 0) begin n_fail++; $display("FAIL first_cmd_seq got=%0d bad exp=0", cmd_mismatches()); end
    n_tests++; if (query_mismatches() != 0) begin n_fail++; $display("FAIL first_query_order got=%0d bad exp=0", query_mismatches()); end
    n_tests++; if (busy_cycles != 3 * NCELL + 1) begin n_fail++; $display("FAIL first_cycles got=%0d exp=%0d", busy_cycles, 3 * NCELL + 1); end
    n_tests++; if (done_count != 1) begin n_fail++; $display("FAIL first_done_count got=%0d exp=1", done_count); end
  endtask

  task automatic single_apple_map();
    set_maps(0);
    diff_map[5 * GW + 3] = 1'b1;
    code_map[5 * GW + 3] = 3'(OBJ_APPLE);
  endtask

  task automatic test_single_diff();
    bit   ok;
    cmd_t e;
    e.x = CW'(3); e.y = CW'(5); e.code = 3'(OBJ_APPLE);
    single_apple_map();
    ready_mode = 0;
    clear_logs();
    start_frame(1'b0);
    wait_done(2000, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_timeout got=no frame_done exp=frame_done"); end
    n_tests++; if (cmd_q.size() != 1) begin n_fail++; $display("FAIL single_cmd_count got=%0d exp=1", cmd_q.size()); end
    if (cmd_q.size() > 0) begin
      n_tests++; if (cmd_q[0] !== e) begin n_fail++; $display("FAIL single_cmd got=%h exp=%h", cmd_q[0], e); end
    end
    n_tests++; if (busy_cycles != 2 * NCELL + 2) begin n_fail++; $display("FAIL single_cycles got=%0d exp=%0d", busy_cycles, 2 * NCELL + 2); end
  endtask

  task automatic test_backpressure();
    bit   ok;
    int   bad = 0;
    cmd_t e;
    e.x = CW'(3); e.y = CW'(5); e.code = 3'(OBJ_APPLE);
    single_apple_map();
    ready_mode = 2;
    stall_x = 3; stall_y = 5; stall_left = 10;
    clear_logs();
    start_frame(1'b0);
    wait_done(2000, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got=no frame_done exp=frame_done"); end
    n_tests++; if (bp_q.size() != 10) begin n_fail++; $display("FAIL bp_valid_cycles got=%0d exp=10", bp_q.size()); end
    foreach (bp_q[i]) if (bp_q[i] !== e) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_payload_stable got=%0d changed exp=0", bad); end
    n_tests++; if (cmd_q.size() != 1) begin n_fail++; $display("FAIL bp_cmd_count got=%0d exp=1", cmd_q.size()); end
    if (q_cyc.size() > 5 * GW + 4) begin
      n_tests++;
      if (q_cyc[5 * GW + 4] != target_hs_cyc + 1) begin
        n_fail++;
        $display("FAIL bp_advance got=cycle %0d exp=cycle %0d", q_cyc[5 * GW + 4], target_hs_cyc + 1);
      end
    end
    n_tests++; if (busy_cycles != 2 * NCELL + 2 + 10) begin n_fail++; $display("FAIL bp_cycles got=%0d exp=%0d", busy_cycles, 2 * NCELL + 12); end
    ready_mode = 0;
    stall_left = 0;
  endtask

  task automatic test_overrun();
    bit ok;
    set_maps(20);
    ready_mode = 0;
    clear_logs();
    build_model(1'b0);
    start_frame(1'b0);
    repeat (300) @(posedge clk);
    #1;
    sync = 1'b1;
    force_full = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
    force_full = 1'b0;
    wait_done(2000, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ovr_timeout got=no frame_done exp=frame_done"); end
    n_tests++; if (overrun_count != 1) begin n_fail++; $display("FAIL ovr_pulses got=%0d exp=1", overrun_count); end
    n_tests++; if (cmd_mismatches() != 0) begin n_fail++; $display("FAIL ovr_cmd_seq got=%0d bad exp=0", cmd_mismatches()); end
    n_tests++; if (query_mismatches() != 0) begin n_fail++; $display("FAIL ovr_query_order got=%0d bad exp=0", query_mismatches()); end
    n_tests++;
    if (busy_cycles != 2 * NCELL + exp_q.size() + 1) begin
      n_fail++;
      $display("FAIL ovr_cycles got=%0d exp=%0d", busy_cycles, 2 * NCELL + exp_q.size() + 1);
    end
    repeat (5) @(posedge clk);
    #1;
    n_tests++; if (done_count != 1) begin n_fail++; $display("FAIL ovr_done_count got=%0d exp=1", done_count); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_no_restart got=busy %b exp=0", busy); end
  endtask

  task automatic test_random_back_to_back();
    bit   ok;
    logic ff;
    ready_mode = 1;
    for (int f = 0; f < 4; f++) begin
      ff = 1'($urandom_range(0, 1));
      set_maps($urandom_range(0, 60));
      clear_logs();
      build_model(ff);
      start_frame(ff);
      wait_done(6000, ok);
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_timeout got=no frame_done exp=frame_done", f); end
      n_tests++; if (cmd_mismatches() != 0) begin n_fail++; $display("FAIL rnd%0d_cmd_seq got=%0d bad exp=0 (full=%b)", f, cmd_mismatches(), ff); end
      n_tests++; if (query_mismatches() != 0) begin n_fail++; $display("FAIL rnd%0d_query_order got=%0d bad exp=0", f, query_mismatches()); end
      n_tests++;
      if (busy_cycles != 2 * NCELL + exp_q.size() + stall_cycles + 1) begin
        n_fail++;
        $display("FAIL rnd%0d_cycles got=%0d exp=%0d", f, busy_cycles, 2 * NCELL + exp_q.size() + stall_cycles + 1);
      end
    end
    ready_mode = 0;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    bit found = 1'b0;
    set_maps(0);
    ready_mode = 2;
    stall_x = 7; stall_y = 2; stall_left = 100000;
    clear_logs();
    start_frame(1'b1);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (cmd_valid && int'(cmd_x) == 7 && int'(cmd_y) == 2) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL rst_mid_reach got=not in SEND at (7,2) exp=SEND"); end
    nrst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({busy, trk_en, cmd_valid, frame_done, overrun} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_mid_ctrl got=%b exp=00000", {busy, trk_en, cmd_valid, frame_done, overrun});
    end
    n_tests++;
    if ({trk_x, trk_y, cmd_x, cmd_y, 3'(cmd_code)} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_data got=%h exp=0", {trk_x, trk_y, cmd_x, cmd_y, 3'(cmd_code)});
    end
    nrst = 1'b1;
    stall_left = 0;
    ready_mode = 0;
    @(posedge clk); #1;
    clear_logs();
    build_model(1'b1);
    start_frame(1'b0);
    wait_done(2000, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_redraw_timeout got=no frame_done exp=frame_done"); end
    n_tests++; if (cmd_q.size() != NCELL) begin n_fail++; $display("FAIL rst_redraw_count got=%0d exp=%0d", cmd_q.size(), NCELL); end
    n_tests++; if (cmd_mismatches() != 0) begin n_fail++; $display("FAIL rst_redraw_seq got=%0d bad exp=0", cmd_mismatches()); end
    n_tests++; if (busy_cycles != 3 * NCELL + 1) begin n_fail++; $display("FAIL rst_redraw_cycles got=%0d exp=%0d", busy_cycles, 3 * NCELL + 1); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_single_diff();
    test_backpressure();
    test_overrun();
    test_random_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
